// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HALT,
    ST_FAULT
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_INC,
    PC_REDIRECT
  } pc_sel_e;

  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] HALT_WORD   = 32'h0;

  // A whole word must lie inside memory; widened by one bit so a pc near the
  // top of the address space cannot wrap into a false "fetchable".
  function automatic logic fetchable(input logic [63:0] addr,
                                     input int unsigned mem_bytes);
    return ({1'b0, addr} + 65'(INSTR_BYTES - 1)) < 65'(mem_bytes);
  endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter register and next-pc selection (hold / +4 / redirect).
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  pc_sel_e     sel,
  input  logic [63:0] redirect_target,
  output logic [63:0] pc
);

  logic [63:0] next_pc;

  // Pick the next pc from the control decision made by the sequencer.
  always_comb begin
    next_pc = pc;
    unique case (sel)
      PC_INC:      next_pc = pc + 64'(INSTR_BYTES);
      PC_REDIRECT: next_pc = redirect_target;
      default:     next_pc = pc;
    endcase
  end

  // PC register; reset restarts fetch at RESET_PC.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pc <= RESET_PC;
    else          pc <= next_pc;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: presents pc to an external memory, registers
// the returned word into a valid/ready output slot, and stops on a zero
// word (HALT) or an unfetchable / misaligned address (FAULT).
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int unsigned IMEM_BYTES = 116
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fetch_count
);

  fetch_state_e state;
  pc_sel_e      pc_sel;
  logic [63:0]  pc;
  logic         accept;
  logic         load_slot;
  logic         word_ok;
  logic         is_halt;
  logic         misaligned;
  logic         do_load;

  fetch_pc_gen #(.RESET_PC(RESET_PC)) u_pc_gen (
    .clk             (clk),
    .reset_n         (reset_n),
    .sel             (pc_sel),
    .redirect_target (redirect_target),
    .pc              (pc)
  );

  assign imem_addr = pc;

  // Per-cycle control decision; redirect outranks stall, load and halt.
  always_comb begin
    accept     = out_valid && out_ready;
    word_ok    = fetchable(pc, IMEM_BYTES);
    is_halt    = (imem_instr == HALT_WORD);
    misaligned = (redirect_target[1:0] != 2'b00);
    load_slot  = (state == ST_RUN) && !redirect_valid && !stall &&
                 (!out_valid || out_ready);
    do_load    = load_slot && word_ok && !is_halt;
    pc_sel     = PC_HOLD;
    if (state != ST_FAULT && redirect_valid && !misaligned) pc_sel = PC_REDIRECT;
    else if (do_load)                                        pc_sel = PC_INC;
  end

  // Sequencer FSM with registered output slot and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_RUN;
      out_valid <= 1'b0;
      out_pc    <= 64'h0;
      out_instr <= 32'h0;
      halted    <= 1'b0;
      fault     <= 1'b0;
    end else begin
      // An accepted word leaves the slot unless something refills it below.
      if (accept) out_valid <= 1'b0;
      unique case (state)
        ST_RUN: begin
          if (redirect_valid) begin
            out_valid <= 1'b0;
            if (misaligned) begin
              state <= ST_FAULT;
              fault <= 1'b1;
            end
          end else if (load_slot) begin
            if (!word_ok) begin
              state     <= ST_FAULT;
              fault     <= 1'b1;
              out_valid <= 1'b0;
            end else if (is_halt) begin
              state  <= ST_HALT;
              halted <= 1'b1;
            end else begin
              out_valid <= 1'b1;
              out_pc    <= pc;
              out_instr <= imem_instr;
            end
          end
        end
        ST_HALT: begin
          out_valid <= 1'b0;
          if (redirect_valid) begin
            halted <= 1'b0;
            if (misaligned) begin
              state <= ST_FAULT;
              fault <= 1'b1;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_FAULT: begin
          out_valid <= 1'b0;
        end
        default: begin
          state     <= ST_FAULT;
          fault     <= 1'b1;
          halted    <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of accepted transfers, including ones under redirect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                  fetch_count <= 32'h0;
    else if (accept && fetch_count != 32'hFFFF_FFFF) fetch_count <= fetch_count + 32'd1;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios with literal expectations
// plus a randomized run checked every cycle against a behavioural model.
module tb_fetch_sequencer;

  localparam int MEM_BYTES = 116;
  localparam int M_RUN = 0, M_HALT = 1, M_FAULT = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_target = 64'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        halted;
  logic        fault;
  logic [31:0] fetch_count;

  logic [31:0] mem [0:31];

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // model state (m_*) and next state (n_*)
  logic [63:0] m_pc, m_opc, n_pc, n_opc;
  logic [31:0] m_oinstr, m_cnt, n_oinstr, n_cnt;
  logic        m_ov, n_ov;
  int          m_mode, n_mode;

  always #5 clk = ~clk;

  fetch_sequencer #(.RESET_PC(64'h0), .IMEM_BYTES(MEM_BYTES)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_instr       (out_instr),
    .halted          (halted),
    .fault           (fault),
    .fetch_count     (fetch_count)
  );

  // external memory: out-of-range reads return a nonzero junk word
  always_comb begin
    if (imem_addr < 64'(MEM_BYTES)) imem_instr = mem[imem_addr[6:2]];
    else                            imem_instr = 32'hDEAD_BEEF;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 64'h0; m_opc = 64'h0; m_oinstr = 32'h0; m_cnt = 32'h0;
    m_ov = 1'b0;  m_mode = M_RUN;
  endtask

  // behavioural next state from the current inputs and model state
  task automatic model_step();
    bit acc;
    n_pc = m_pc; n_opc = m_opc; n_oinstr = m_oinstr; n_cnt = m_cnt;
    n_ov = m_ov; n_mode = m_mode;
    acc = m_ov && out_ready;
    if (acc) begin
      n_ov = 1'b0;
      if (m_cnt != 32'hFFFF_FFFF) n_cnt = m_cnt + 1;
    end
    if (m_mode != M_FAULT) begin
      if (redirect_valid) begin
        n_ov = 1'b0;
        if (redirect_target % 4 != 0) n_mode = M_FAULT;
        else begin
          n_pc = redirect_target;
          n_mode = M_RUN;
        end
      end else if (m_mode == M_RUN && !stall && (!m_ov || out_ready)) begin
        if (m_pc + 3 >= MEM_BYTES) n_mode = M_FAULT;
        else if (mem[m_pc / 4] == 32'h0) n_mode = M_HALT;
        else begin
          n_ov = 1'b1; n_opc = m_pc; n_oinstr = mem[m_pc / 4]; n_pc = m_pc + 4;
        end
      end
    end
  endtask

  // one clock: model sees the same inputs as the DUT, commits at the edge
  task automatic clk_cycle();
    model_step();
    @(posedge clk);
    m_pc = n_pc; m_opc = n_opc; m_oinstr = n_oinstr; m_cnt = n_cnt;
    m_ov = n_ov; m_mode = n_mode;
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("imem_addr", imem_addr, m_pc);
      check("out_valid", 64'(out_valid), 64'(m_ov));
      if (m_ov) begin
        check("out_pc", out_pc, m_opc);
        check("out_instr", 64'(out_instr), 64'(m_oinstr));
      end
      check("halted", 64'(halted), 64'(m_mode == M_HALT));
      check("fault", 64'(fault), 64'(m_mode == M_FAULT));
      check("fetch_count", 64'(fetch_count), 64'(m_cnt));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] last_pc;
    bit          got_fault;
    int          fault_cycles;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0000_0013 | (32'(i) << 20);
    mem[0] = 32'h0030_0593;   // addi x11,x0,3
    mem[1] = 32'h0015_8593;   // addi x11,x11,1
    mem[2] = 32'h0000_0000;   // halt word
    model_reset();
    #2;
    apply_reset();
    chk_en = 1'b1;

    // reset values, then two fetches and halt
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_out_pc", out_pc, 64'h0);
    check("rst_out_instr", 64'(out_instr), 64'h0);
    check("rst_count", 64'(fetch_count), 64'h0);
    check("rst_halted", 64'(halted), 64'h0);
    check("rst_fault", 64'(fault), 64'h0);
    out_ready = 1'b1;
    clk_cycle();
    check("seq_v0", 64'(out_valid), 64'h1);
    check("seq_pc0", out_pc, 64'h0);
    check("seq_i0", 64'(out_instr), 64'h0030_0593);
    clk_cycle();
    check("seq_pc4", out_pc, 64'h4);
    check("seq_i4", 64'(out_instr), 64'h0015_8593);
    check("seq_cnt1", 64'(fetch_count), 64'h1);
    clk_cycle();
    check("halt_flag", 64'(halted), 64'h1);
    check("halt_v", 64'(out_valid), 64'h0);
    check("halt_cnt", 64'(fetch_count), 64'h2);
    check("halt_pc", imem_addr, 64'h8);
    clk_cycle();
    check("halt_hold", imem_addr, 64'h8);

    // backpressure holds the slot
    mem[2] = 32'h0020_0613;
    apply_reset();
    clk_cycle();
    clk_cycle();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      clk_cycle();
      check("bp_pc", out_pc, 64'h4);
      check("bp_instr", 64'(out_instr), 64'h0015_8593);
      check("bp_addr", imem_addr, 64'h8);
      check("bp_cnt", 64'(fetch_count), 64'h1);
    end
    out_ready = 1'b1;
    clk_cycle();
    check("bp_resume", out_pc, 64'h8);
    check("bp_resume_cnt", 64'(fetch_count), 64'h2);

    // redirect flushes a stalled output
    apply_reset();
    out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_target = 64'd40;
    clk_cycle();
    redirect_valid = 1'b0;
    clk_cycle();
    check("rd_pc40", out_pc, 64'd40);
    redirect_valid = 1'b1; redirect_target = 64'd44;
    clk_cycle();
    check("rd_flush", 64'(out_valid), 64'h0);
    check("rd_cnt", 64'(fetch_count), 64'h0);
    redirect_valid = 1'b0;
    clk_cycle();
    check("rd_pc44", out_pc, 64'd44);
    check("rd_i44", 64'(out_instr), 64'h00B0_0013);
    // accept in the same cycle as a redirect still counts
    out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_target = 64'd0;
    clk_cycle();
    check("rd_acc_cnt", 64'(fetch_count), 64'h1);
    check("rd_acc_addr", imem_addr, 64'h0);

    // misaligned redirect faults until reset
    redirect_target = 64'h2A;
    clk_cycle();
    check("mis_fault", 64'(fault), 64'h1);
    check("mis_pc", imem_addr, 64'h0);
    redirect_target = 64'd8;
    for (int k = 0; k < 3; k++) begin
      clk_cycle();
      check("mis_sticky", 64'(fault), 64'h1);
      check("mis_nov", 64'(out_valid), 64'h0);
    end
    redirect_valid = 1'b0;

    // run off the end of memory
    apply_reset();
    redirect_valid = 1'b1; redirect_target = 64'd100;
    clk_cycle();
    redirect_valid = 1'b0;
    last_pc = 64'h0;
    got_fault = 1'b0;
    for (int k = 0; k < 12 && !got_fault; k++) begin
      clk_cycle();
      if (out_valid) last_pc = out_pc;
      got_fault = fault;
    end
    check("end_fault", 64'(got_fault), 64'h1);
    check("end_last_pc", last_pc, 64'd112);
    check("end_cnt", 64'(fetch_count), 64'd4);
    apply_reset();
    check("end_rst_cnt", 64'(fetch_count), 64'h0);
    clk_cycle();
    check("end_rst_pc", out_pc, 64'h0);
    check("end_rst_v", 64'(out_valid), 64'h1);

    // stall with redirect, then stall alone
    apply_reset();
    out_ready = 1'b0;
    clk_cycle();
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 64'd8;
    clk_cycle();
    check("st_rd_pc", imem_addr, 64'd8);
    redirect_valid = 1'b0;
    clk_cycle();
    check("st_hold_pc", imem_addr, 64'd8);
    check("st_hold_v", 64'(out_valid), 64'h0);
    stall = 1'b0;
    clk_cycle();
    check("st_load", out_pc, 64'd8);

    // randomized run
    for (int i = 0; i < 32; i++) mem[i] = ($urandom_range(0, 11) == 0) ? 32'h0 : ($urandom | 32'h1);
    apply_reset();
    fault_cycles = 0;
    for (int c = 0; c < 4000; c++) begin
      stall          = ($urandom_range(0, 3) == 0);
      out_ready      = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_target = 64'($urandom_range(0, 31)) * 4 +
                        (($urandom_range(0, 15) == 0) ? 64'($urandom_range(1, 3)) : 64'h0);
      clk_cycle();
      fault_cycles = (m_mode == M_FAULT) ? fault_cycles + 1 : 0;
      if (fault_cycles > 3 || $urandom_range(0, 299) == 0) begin
        for (int i = 0; i < 32; i++) mem[i] = ($urandom_range(0, 11) == 0) ? 32'h0 : ($urandom | 32'h1);
        apply_reset();
        fault_cycles = 0;
      end
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0: program counter value loaded on reset.
REQ-002 SHALL have parameter IMEM_BYTES, default 116: instruction memory size in bytes; a word is fetchable only if pc+3 < IMEM_BYTES.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port imem_addr, output, 64 bits: byte address to instruction memory, equal to pc (combinational).
REQ-006 SHALL have port imem_instr, input, 32 bits: little-endian word returned combinationally for imem_addr.
REQ-007 SHALL have port stall, input, 1 bit: hold fetch this cycle.
REQ-008 SHALL have port redirect_valid, input, 1 bit: branch/jump taken this cycle.
REQ-009 SHALL have port redirect_target, input, 64 bits: new byte-address pc.
REQ-010 SHALL have port out_valid, output, 1 bit: out_pc/out_instr hold a fetched instruction.
REQ-011 SHALL have port out_ready, input, 1 bit: decode accepts the instruction.
REQ-012 SHALL have port out_pc, output, 64 bits: address of the presented instruction.
REQ-013 SHALL have port out_instr, output, 32 bits: the presented instruction.
REQ-014 SHALL have port halted, output, 1 bit: high in state HALT.
REQ-015 SHALL have port fault, output, 1 bit: high in state FAULT.
REQ-016 SHALL have port fetch_count, output, 32 bits: count of accepted transfers (out_valid && out_ready), saturating at 32'hFFFF_FFFF.

Function
REQ-017 SHALL implement states RUN, HALT and FAULT; the state after reset is RUN.
REQ-018 SHALL, in RUN, load the output register when !stall && (!out_valid || out_ready) && the word is fetchable: out_pc<=pc, out_instr<=imem_instr, out_valid<=1, pc<=pc+4.
REQ-019 SHALL give a latency of one cycle from pc presentation to out_valid.
REQ-020 SHALL hold out_pc/out_instr stable while out_valid && !out_ready.
REQ-021 SHALL clear out_valid after an accept when no new load occurs in the same cycle.
REQ-022 SHALL, when imem_instr==32'h0 at a load point, not emit that word, leave pc unchanged, and enter HALT.
REQ-023 SHALL, when the word is not fetchable at a load point, enter FAULT without loading.
REQ-024 SHALL give redirect_valid priority over stall, load and halt detection: pc<=redirect_target, out_valid<=0 (flush, even if out_valid && !out_ready), fetch_count unchanged by the flushed word.
REQ-025 SHALL enter FAULT, with out_valid<=0 and pc unchanged, when redirect_target[1:0]!=0.
REQ-026 SHALL, in HALT, issue no loads; an aligned redirect returns to RUN at redirect_target.
REQ-027 SHALL leave FAULT only by reset; out_valid SHALL remain 0 in FAULT.
REQ-028 SHALL count an accept occurring in the same cycle as a redirect.

Reset
REQ-029 SHALL on reset_n low immediately set pc=RESET_PC, state=RUN, out_valid=0, out_pc=0, out_instr=0, fetch_count=0, halted=0, fault=0.
REQ-030 SHALL discard any in-flight instruction on reset mid-operation; the first load after release is at RESET_PC.

Structure
REQ-031 SHALL place the state enum, INSTR_BYTES=4 and HALT_WORD=32'h0 in a shared package fetch_pkg.
REQ-032 SHALL implement next-pc selection (pc+4, redirect, hold) in one sub-module fetch_pc_gen; the memory stays external.

Verification
REQ-033 SHALL cover: reset, out_ready=1, memory {addi x11,x0,3; addi x11,x11,1; 0} -> out_pc 0,4 on consecutive cycles, then halted=1, fetch_count=2.
REQ-034 SHALL cover: out_ready=0 for 3 cycles while out_pc=4 is valid -> out_pc/out_instr held, pc stays 8, no count.
REQ-035 SHALL cover: redirect to 44 while out_pc=40 is valid and out_ready=0 -> next cycle out_valid=0, then out_pc=44.
REQ-036 SHALL cover: redirect to 0x2A -> fault=1, out_valid stays 0 until reset.
REQ-037 SHALL cover: sequential fetch reaching pc=116 -> fault=1; then reset_n pulse -> next out_pc=0, fetch_count=0.
REQ-038 SHALL cover: stall=1 together with redirect to 8 -> pc=8 next cycle; stall=1 alone -> pc unchanged.
